// File: rtl/scancode_decoder.sv
// rtl/scancode_decoder.sv - PS/2 set-2 scancode decoder with prefix timeout; TYPEMATIC_FILTER_EN adds auto-repeat suppression
module scancode_decoder #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic [3:0] answer,
    output logic       key_pressed,
    output logic       seq_error
);

    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [3:0] CLS_UP    = 4'd1;
    localparam logic [3:0] CLS_DOWN  = 4'd2;
    localparam logic [3:0] CLS_LEFT  = 4'd3;
    localparam logic [3:0] CLS_RIGHT = 4'd4;
    localparam logic [3:0] CLS_VOWEL = 4'd5;
    localparam logic [3:0] CLS_DIGIT = 4'd6;
    localparam logic [3:0] CLS_OTHER = 4'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK
    } state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   to_cnt, to_cnt_nx;
    logic            make_hit;
    logic            make_ext;
    logic            timeout;
    logic            repeat_hit;
    logic            press;
    logic [3:0]      cls;

    // Arrow keys only exist as extended codes; keypad twins fall to OTHER.
    function automatic logic [3:0] classify(input logic ext, input logic [7:0] b);
        logic [3:0] c;
        c = CLS_OTHER;
        if (ext) begin
            case (b)
                8'h75:   c = CLS_UP;
                8'h72:   c = CLS_DOWN;
                8'h6B:   c = CLS_LEFT;
                8'h74:   c = CLS_RIGHT;
                default: c = CLS_OTHER;
            endcase
        end else begin
            case (b)
                8'h1C, 8'h24, 8'h43, 8'h44, 8'h3C:                      c = CLS_VOWEL;
                8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46:                      c = CLS_DIGIT;
                default:                                               c = CLS_OTHER;
            endcase
        end
        return c;
    endfunction

    // Prefix state register and idle counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            to_cnt <= '0;
        end else begin
            state  <= state_nx;
            to_cnt <= to_cnt_nx;
        end
    end

    // Next-state: byte handling first, timeout only on cycles without a byte
    always_comb begin
        state_nx = state;
        make_hit = 1'b0;
        make_ext = 1'b0;
        timeout  = 1'b0;
        if (byte_valid) begin
            case (state)
                S_IDLE: begin
                    if (byte_data == 8'hE0) begin
                        state_nx = S_EXT;
                    end else if (byte_data == 8'hF0) begin
                        state_nx = S_BRK;
                    end else if (byte_data == 8'hAA || byte_data == 8'hFA ||
                                 byte_data == 8'hFE || byte_data == 8'hE1) begin
                        state_nx = S_IDLE;
                    end else begin
                        make_hit = 1'b1;
                    end
                end
                S_EXT: begin
                    if (byte_data == 8'hF0) begin
                        state_nx = S_EXT_BRK;
                    end else if (byte_data == 8'hE0) begin
                        state_nx = S_EXT;
                    end else begin
                        make_hit = 1'b1;
                        make_ext = 1'b1;
                        state_nx = S_IDLE;
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end else if (state != S_IDLE && to_cnt == TO_LAST) begin
            timeout  = 1'b1;
            state_nx = S_IDLE;
        end
    end

    // Idle counter: cleared by any byte, advances only mid-sequence, saturates
    always_comb begin
        to_cnt_nx = '0;
        if (!byte_valid && !timeout && state != S_IDLE) begin
            to_cnt_nx = (to_cnt == TO_LAST) ? to_cnt : to_cnt + 1'b1;
        end
    end

`ifdef TYPEMATIC_FILTER_EN
    logic       held_vld;
    logic [8:0] held;
    logic       brk_hit;
    logic       brk_ext;

    // Break completes on any byte in either break state
    always_comb begin
        brk_hit = byte_valid && (state == S_BRK || state == S_EXT_BRK);
        brk_ext = (state == S_EXT_BRK);
    end

    // Held key: set by each accepted make, released by its own break
    always_ff @(posedge clk) begin
        if (reset) begin
            held_vld <= 1'b0;
            held     <= '0;
        end else if (make_hit) begin
            held_vld <= 1'b1;
            held     <= {make_ext, byte_data};
        end else if (brk_hit && held_vld && held == {brk_ext, byte_data}) begin
            held_vld <= 1'b0;
            held     <= '0;
        end
    end

    // Auto-repeat of the held key is swallowed
    always_comb begin
        repeat_hit = held_vld && (held == {make_ext, byte_data});
    end
`else
    // Every make code reports, repeats included
    always_comb begin
        repeat_hit = 1'b0;
    end
`endif

    // Press qualification and class lookup
    always_comb begin
        press = make_hit && !repeat_hit;
        cls   = classify(make_ext, byte_data);
    end

    // Registered outputs: answer holds until the next accepted press
    always_ff @(posedge clk) begin
        if (reset) begin
            answer      <= 4'd0;
            key_pressed <= 1'b0;
            seq_error   <= 1'b0;
        end else begin
            key_pressed <= press;
            seq_error   <= timeout;
            if (press) begin
                answer <= cls;
            end
        end
    end

endmodule
